// File: rtl/i2s_audio_tx.sv
// Philips I2S stereo transmitter with one-deep sample holding register.
// Optional I2S_TX_UNDERRUN_ZERO_EN: underrun frames send silence, not a repeat.
module i2s_audio_tx #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4
) (
  input  logic                     data_clk,
  input  logic                     reset_data,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     underrun_clr,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_data,
  output logic                     frame_start,
  output logic                     underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
  logic                     bclk_q, bclk_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                     lrclk_q, lrclk_d;
  logic                     data_q, data_d;
  logic [FRAME_BITS-1:0]    shreg_q, shreg_d;
  logic                     fs_q, fs_d;
  logic                     underrun_q, underrun_d;
  logic                     hold_full_q, hold_full_d;
  logic [AUD_BIT_DEPTH-1:0] hold_l_q, hold_l_d;
  logic [AUD_BIT_DEPTH-1:0] hold_r_q, hold_r_d;
  logic [AUD_BIT_DEPTH-1:0] last_l_q, last_l_d;
  logic [AUD_BIT_DEPTH-1:0] last_r_q, last_r_d;

  logic                     div_wrap;
  logic                     fall_tick;
  logic                     load;
  logic                     accept;
  logic                     ld_sample;
  logic [AUD_BIT_DEPTH-1:0] ld_l, ld_r;
  logic [SLOT_BITS-1:0]     slot_l, slot_r;

  assign sample_ready = !hold_full_q;
  assign accept       = sample_valid && !hold_full_q;

  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_data    = data_q;
  assign frame_start = fs_q;
  assign underrun    = underrun_q;

  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    fall_tick = div_wrap && bclk_q;
    load      = fall_tick && (bit_cnt_q == BIT_LAST);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = div_wrap ? !bclk_q : bclk_q;
  end

  // Hold and bypass are exclusive since bypass needs an empty hold
  always_comb begin
    ld_sample = 1'b0;
    ld_l      = last_l_q;
    ld_r      = last_r_q;
    unique case (1'b1)
      hold_full_q: begin
        ld_sample = 1'b1;
        ld_l      = hold_l_q;
        ld_r      = hold_r_q;
      end
      accept: begin
        ld_sample = 1'b1;
        ld_l      = lsound_in;
        ld_r      = rsound_in;
      end
      default: begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        ld_l = '0;
        ld_r = '0;
`else
        ld_l = last_l_q;
        ld_r = last_r_q;
`endif
      end
    endcase
  end

  always_comb begin
    slot_l = '0;
    slot_r = '0;
    slot_l[SLOT_BITS-1 -: AUD_BIT_DEPTH] = ld_l;
    slot_r[SLOT_BITS-1 -: AUD_BIT_DEPTH] = ld_r;
  end

  // Data takes the pre-shift MSB, giving the one-BCLK I2S delay
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    data_d    = data_q;
    shreg_d   = shreg_q;
    fs_d      = 1'b0;
    if (fall_tick) begin
      bit_cnt_d = load ? '0 : bit_cnt_q + BIT_W'(1);
      lrclk_d   = (bit_cnt_d >= BIT_SLOT);
      data_d    = shreg_q[FRAME_BITS-1];
      shreg_d   = load ? {slot_l, slot_r}
                       : {shreg_q[FRAME_BITS-2:0], 1'b0};
      fs_d      = load;
    end
  end

  always_comb begin
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
    underrun_d  = underrun_q;
    if (underrun_clr)
      underrun_d = 1'b0;
    if (load) begin
      if (ld_sample) begin
        last_l_d = ld_l;
        last_r_d = ld_r;
      end else begin
        underrun_d = 1'b1;
      end
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = lsound_in;
      hold_r_d    = rsound_in;
    end
  end

  always_ff @(posedge data_clk or posedge reset_data) begin
    if (reset_data) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= BIT_LAST;
      lrclk_q     <= 1'b1;
      data_q      <= 1'b0;
      shreg_q     <= '0;
      fs_q        <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      last_l_q    <= '0;
      last_r_q    <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      data_q      <= data_d;
      shreg_q     <= shreg_d;
      fs_q        <= fs_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: frames decoded from the serial line
// are checked against a queue of expected frames.
module tb_i2s_audio_tx;

  logic        clk;
  logic        rst;
  logic [23:0] l_in;
  logic [23:0] r_in;
  logic        valid;
  logic        ready;
  logic        clr;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        fs;
  logic        urun;

  int n_assert = 0;
  int n_fail   = 0;
  int nframes  = 0;

  logic [63:0] expq[$];

  logic [62:0] cur;
  int          cnt;
  bit          pend;
  bit          started;
  logic        pb;

  i2s_audio_tx dut (
    .data_clk     (clk),
    .reset_data   (rst),
    .lsound_in    (l_in),
    .rsound_in    (r_in),
    .sample_valid (valid),
    .sample_ready (ready),
    .underrun_clr (clr),
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_data     (sdata),
    .frame_start  (fs),
    .underrun     (urun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] frm(input logic [23:0] l,
                                      input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    l_in  = l;
    r_in  = r;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    l_in  = '0;
    r_in  = '0;
  endtask

  task automatic wait_load(input string tag);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (fs === 1'b1) break;
    end
    chk(tag, 64'(fs), 64'd1);
  endtask

  // Rebuild frames: first BCLK rise after a load carries the previous
  // frame's LSB, then the next 63 rises carry the new frame MSB-first.
  always @(negedge clk) begin
    if (rst) begin
      cnt     = 0;
      pend    = 1'b0;
      started = 1'b0;
      pb      = 1'b0;
    end else begin
      if (fs) pend = 1'b1;
      if (bclk && !pb) begin
        if (pend) begin
          if (started && cnt == 63) begin
            nframes++;
            if (expq.size() == 0)
              chk("frame_unexpected", {cur, sdata}, 64'hx);
            else
              chk("frame_data", {cur, sdata}, expq.pop_front());
          end
          started = 1'b1;
          cnt     = 0;
          pend    = 1'b0;
        end else if (started && cnt < 63) begin
          cur = {cur[61:0], sdata};
          cnt++;
        end
      end
      pb = bclk;
    end
  end

  logic [23:0] ur_pay;

  initial begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    ur_pay = 24'h000000;
`else
    ur_pay = 24'h123456;
`endif
    rst   = 1'b1;
    valid = 1'b0;
    clr   = 1'b0;
    l_in  = '0;
    r_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrclk", 64'(lrclk), 64'd1);
    chk("rst_data", 64'(sdata), 64'd0);
    chk("rst_fs", 64'(fs), 64'd0);
    chk("rst_urun", 64'(urun), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);

    // T1: divider and first load
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_bclk_c3", 64'(bclk), 64'd0);
    @(negedge clk);
    chk("t1_bclk_c4", 64'(bclk), 64'd1);
    repeat (3) @(negedge clk);
    chk("t1_bclk_c7", 64'(bclk), 64'd1);
    chk("t1_fs_c7", 64'(fs), 64'd0);
    @(negedge clk);
    chk("t1_bclk_c8", 64'(bclk), 64'd0);
    chk("t1_fs_c8", 64'(fs), 64'd1);
    chk("t1_lrclk_c8", 64'(lrclk), 64'd0);
    chk("t1_urun", 64'(urun), 64'd1);
    expq.push_back(frm(24'h0, 24'h0));

    // T2: held sample
    repeat (20) @(negedge clk);
    send(24'hA5A5A5, 24'h5A5A5A);
    chk("t2_ready_lo", 64'(ready), 64'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t2_urun_clr", 64'(urun), 64'd0);
    expq.push_back(frm(24'hA5A5A5, 24'h5A5A5A));
    wait_load("t2_load");
    chk("t2_ready_hi", 64'(ready), 64'd1);
    chk("t2_urun", 64'(urun), 64'd0);

    // T3: bypass on the exact load cycle (loads every 512 cycles)
    repeat (300) @(negedge clk);
    chk("t3_lrclk_right", 64'(lrclk), 64'd1);
    repeat (211) @(negedge clk);
    l_in  = 24'h7FFFFF;
    r_in  = 24'h800000;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    l_in  = '0;
    r_in  = '0;
    chk("t3_fs", 64'(fs), 64'd1);
    chk("t3_ready", 64'(ready), 64'd1);
    chk("t3_urun", 64'(urun), 64'd0);
    expq.push_back(frm(24'h7FFFFF, 24'h800000));

    // T4: second valid while full is dropped
    repeat (20) @(negedge clk);
    send(24'h123456, 24'h123456);
    chk("t4_ready_lo", 64'(ready), 64'd0);
    repeat (10) @(negedge clk);
    send(24'h111111, 24'h111111);
    chk("t4_ready_still_lo", 64'(ready), 64'd0);
    expq.push_back(frm(24'h123456, 24'h123456));
    wait_load("t4_load");
    chk("t4_ready_hi", 64'(ready), 64'd1);
    chk("t4_urun", 64'(urun), 64'd0);

    // T5: underrun payload
    expq.push_back(frm(ur_pay, ur_pay));
    wait_load("t5_load");
    chk("t5_urun", 64'(urun), 64'd1);

    // T6: clear coinciding with an underrun load
    repeat (30) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t6_urun_clr", 64'(urun), 64'd0);
    repeat (480) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t6_fs", 64'(fs), 64'd1);
    chk("t6_urun_set_wins", 64'(urun), 64'd1);
    expq.push_back(frm(ur_pay, ur_pay));

    // T7: reset mid right slot with a held sample
    wait_load("t7_load");
    repeat (20) @(negedge clk);
    send(24'h0F0F0F, 24'hF0F0F0);
    chk("t7_ready_lo", 64'(ready), 64'd0);
    repeat (300) @(negedge clk);
    chk("t7_lrclk_pre", 64'(lrclk), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_bclk", 64'(bclk), 64'd0);
    chk("t7_lrclk", 64'(lrclk), 64'd1);
    chk("t7_data", 64'(sdata), 64'd0);
    chk("t7_ready", 64'(ready), 64'd1);
    chk("t7_urun", 64'(urun), 64'd0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    chk("t7_fs_c7", 64'(fs), 64'd0);
    @(negedge clk);
    chk("t7_fs_c8", 64'(fs), 64'd1);
    chk("t7_bclk_c8", 64'(bclk), 64'd0);
    chk("t7_urun_lost", 64'(urun), 64'd1);
    expq.push_back(frm(24'h0, 24'h0));

    repeat (20) @(negedge clk);
    send(24'h000001, 24'hFFFFFF);
    expq.push_back(frm(24'h000001, 24'hFFFFFF));
    wait_load("post_load1");
    wait_load("post_load2");
    repeat (6) @(negedge clk);
    chk("exp_queue_empty", 64'(expq.size()), 64'd0);
    chk("frames_seen", 64'(nframes), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
